// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NUM_REQ
// requesters, with a registered issue stage and one held response slot each.
module alu_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int OP_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic                          alu_valid,
  output logic [OP_WIDTH-1:0]           alu_op,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  output logic                          alu_cin,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic [3:0]                    alu_flags,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_result,
  output logic [NUM_REQ*4-1:0]          rsp_flags,
  output logic                          idle
);

  localparam int TW = $clog2(NUM_REQ);

  logic [TW-1:0]                 r_ptr;
  logic [TW-1:0]                 r_tag;
  logic                          r_issue_valid;
  logic [OP_WIDTH-1:0]           r_op;
  logic [DATA_WIDTH-1:0]         r_a;
  logic [DATA_WIDTH-1:0]         r_b;
  logic                          r_cin;
  logic [NUM_REQ-1:0]            r_rsp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] r_rsp_result;
  logic [NUM_REQ*4-1:0]          r_rsp_flags;

  logic [NUM_REQ-1:0]            w_inflight;
  logic [NUM_REQ-1:0]            w_elig;
  logic [NUM_REQ-1:0]            w_grant;
  logic [TW-1:0]                 w_gnt_idx;
  logic                          w_hs;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_inflight[i] = r_issue_valid && (r_tag == TW'(i));
    end
  end

  // Eligibility uses registered slot state only, so rsp_ready never reaches req_ready.
  assign w_elig = rst ? '0 : (req_valid & ~r_rsp_valid & ~w_inflight);

  always_comb begin
    logic [TW-1:0] sel;
    w_grant   = '0;
    w_gnt_idx = r_ptr;
    w_hs      = 1'b0;
    sel       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = TW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_hs && w_elig[sel]) begin
        w_hs         = 1'b1;
        w_grant[sel] = 1'b1;
        w_gnt_idx    = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr         <= TW'(NUM_REQ - 1);
      r_tag         <= '0;
      r_issue_valid <= 1'b0;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_cin         <= 1'b0;
    end else begin
      r_issue_valid <= w_hs;
      if (w_hs) begin
        r_ptr <= w_gnt_idx;
        r_tag <= w_gnt_idx;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i]) begin
          r_op  <= req_op[i*OP_WIDTH +: OP_WIDTH];
          r_a   <= req_a[i*DATA_WIDTH +: DATA_WIDTH];
          r_b   <= req_b[i*DATA_WIDTH +: DATA_WIDTH];
          r_cin <= req_cin[i];
        end
      end
    end
  end

  // Capture and drain never hit the same slot in one cycle; capture wins regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_inflight[i]) begin
          r_rsp_valid[i]                        <= 1'b1;
          r_rsp_result[i*DATA_WIDTH +: DATA_WIDTH] <= alu_result;
          r_rsp_flags[i*4 +: 4]                 <= alu_flags;
        end else if (r_rsp_valid[i] && rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign req_ready  = w_grant;
  assign alu_valid  = r_issue_valid;
  assign alu_op     = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_cin    = r_cin;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign idle       = !r_issue_valid && !(|r_rsp_valid);

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_grant_valid:   assert property (@(posedge clk) disable iff (rst) (req_ready & ~req_valid) == '0);
  a_capture_empty: assert property (@(posedge clk) disable iff (rst) (w_inflight & r_rsp_valid) == '0);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a stub ALU, a queue-based reference
// model of grants/latency/responses, directed scenarios and a random phase.
module tb_alu_share_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int OW = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_CMP  = 4'd5;
  localparam logic [3:0] OP_TEST = 4'd6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, req_cin;
  logic [NR*OW-1:0]  req_op;
  logic [NR*DW-1:0]  req_a, req_b;
  logic              alu_valid, alu_cin;
  logic [OW-1:0]     alu_op;
  logic [DW-1:0]     alu_a, alu_b, alu_result;
  logic [3:0]        alu_flags;
  logic [NR-1:0]     rsp_valid, rsp_ready;
  logic [NR*DW-1:0]  rsp_result;
  logic [NR*4-1:0]   rsp_flags;
  logic              idle;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  alu_share_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .idle(idle)
  );

  always #5 clk = ~clk;

  // Returns {Z,N,C,V, result}.
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
    logic [16:0] w;
    logic cf, vf;
    w = '0; cf = 1'b0; vf = 1'b0;
    case (op)
      OP_ADD: begin
        w  = {1'b0, a} + {1'b0, b} + {16'd0, c};
        cf = w[16];
        vf = (a[15] == b[15]) && (w[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        w  = {1'b0, a} - {1'b0, b};
        cf = w[16];
        vf = (a[15] != b[15]) && (w[15] != a[15]);
      end
      OP_AND, OP_TEST: w = {1'b0, a & b};
      OP_OR:           w = {1'b0, a | b};
      OP_XOR:          w = {1'b0, a ^ b};
      default:         w = {1'b0, a};
    endcase
    return {(w[15:0] == 16'd0), w[15], cf, vf, w[15:0]};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [19:0] fr;
    int          cyc;
  } exp_t;

  exp_t        sb [NR][$];
  int          ptr_m;
  int          last_hs;
  logic [36:0] last_iss;

  // Monitor / reference model, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic [NR-1:0] e_gnt, e_rsp;
    bit            empty, found;
    int            g;
    exp_t          e;
    if (rst) begin
      chk("reset_outs", {req_ready, alu_valid, rsp_valid, idle}, {4'b0, 1'b0, 4'b0, 1'b1});
      chk("reset_data", {alu_op, alu_a, alu_b, alu_cin, (|rsp_result), (|rsp_flags)}, 64'd0);
      for (int i = 0; i < NR; i++) sb[i].delete();
      ptr_m   = NR - 1;
      last_hs = -10;
    end else begin
      e_gnt = '0; found = 0; g = 0;
      for (int k = 1; k <= NR; k++) begin
        int idx;
        idx = (ptr_m + k) % NR;
        if (!found && req_valid[idx] && sb[idx].size() == 0) begin
          found = 1; g = idx; e_gnt[idx] = 1'b1;
        end
      end
      chk("req_ready", req_ready, e_gnt);
      chk("alu_valid", alu_valid, (last_hs == cyc - 1));
      if (last_hs == cyc - 1) chk("alu_issue", {alu_op, alu_a, alu_b, alu_cin}, last_iss);
      empty = 1;
      for (int i = 0; i < NR; i++) begin
        e_rsp[i] = (sb[i].size() > 0) && (sb[i][0].cyc <= cyc - 2);
        if (sb[i].size() > 0) empty = 0;
      end
      chk("rsp_valid", rsp_valid, e_rsp);
      chk("idle", idle, empty);
      for (int i = 0; i < NR; i++) begin
        if (e_rsp[i] && rsp_valid[i]) begin
          chk($sformatf("rsp_data%0d", i), {rsp_flags[i*4 +: 4], rsp_result[i*DW +: DW]}, sb[i][0].fr);
          if (rsp_ready[i]) void'(sb[i].pop_front());
        end
      end
      if (found) begin
        e.fr  = alu_fn(req_op[g*OW +: OW], req_a[g*DW +: DW], req_b[g*DW +: DW], req_cin[g]);
        e.cyc = cyc;
        sb[g].push_back(e);
        ptr_m    = g;
        last_hs  = cyc;
        last_iss = {req_op[g*OW +: OW], req_a[g*DW +: DW], req_b[g*DW +: DW], req_cin[g]};
      end
    end
    cyc++;
  end

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
    req_op[i*OW +: OW] = op;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
    req_cin[i]         = c;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++)
      set_req(i, 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0; req_cin = '0;
    step(3);
    rst = 1'b0;

    // single ADD, full latency and return to idle
    set_req(0, OP_ADD, 16'h0003, 16'h0004, 1'b0);
    req_valid = 4'b0001; rsp_ready = 4'b1111;
    step(1); req_valid = '0;
    step(4);
    chk("t1_idle", idle, 1'b1);

    // all four requesters continuously
    for (int n = 0; n < 16; n++) begin
      req_valid = 4'b1111; rand_data(); step(1);
    end
    req_valid = '0; step(5);

    // response stall on requester 1 while requester 2 keeps getting served
    rsp_ready = 4'b1101;
    set_req(1, OP_SUB, 16'h0000, 16'h0001, 1'b0);
    req_valid = 4'b0010;
    step(1);
    for (int n = 0; n < 10; n++) begin
      req_valid = 4'b0110;
      set_req(2, 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b0);
      step(1);
      if (n == 3) chk("t3_hold", {rsp_valid[1], rsp_flags[6], rsp_result[31:16]}, {1'b1, 1'b1, 16'hFFFF});
    end
    req_valid = '0; rsp_ready = 4'b1111; step(4);

    // CMP equal operands sets Z
    set_req(3, OP_CMP, 16'h1234, 16'h1234, 1'b0);
    req_valid = 4'b1000;
    step(1); req_valid = '0;
    step(1);
    chk("t4_cmp_z", {rsp_valid[3], rsp_flags[15]}, 2'b11);
    step(3);

    // async reset with an op in flight and slot 2 full
    rsp_ready = 4'b1011;
    set_req(2, OP_XOR, 16'hA5A5, 16'h0F0F, 1'b0);
    req_valid = 4'b0100;
    step(1); req_valid = '0;
    waited = 0;
    while (!rsp_valid[2] && waited < 20) begin step(1); waited++; end
    chk("t5_slot2_timeout", (waited < 20), 1'b1);
    set_req(0, OP_OR, 16'h1100, 16'h0011, 1'b0);
    req_valid = 4'b0001;
    step(1); req_valid = '0;
    chk("t5_pre", {alu_valid, rsp_valid[2]}, 2'b11);
    #1 rst = 1'b1;
    #1 chk("t5_async", {alu_valid, rsp_valid}, 5'b0);
    step(2);
    rsp_ready = 4'b1111; rand_data(); req_valid = 4'b1111;
    rst = 1'b0;
    #1 chk("t5_first_grant", req_ready, 4'b0001);
    step(8); req_valid = '0; step(5);

    // pointer parked at 2, next search starts at 3
    set_req(2, OP_ADD, 16'h0001, 16'h0001, 1'b1);
    req_valid = 4'b0100;
    step(1); req_valid = '0; step(4);
    rand_data(); req_valid = 4'b1101;
    #1 chk("t6_after_ptr2", req_ready, 4'b1000);
    step(6); req_valid = '0; step(4);

    // random phase
    for (int n = 0; n < 1500; n++) begin
      rand_data();
      req_valid = 4'($urandom);
      for (int i = 0; i < NR; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req_valid = '0; rsp_ready = 4'b1111; step(6);
    chk("final_idle", idle, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
